// File: rtl/bm_mem_rd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bm_mem_rd_seq
// Brief   : Bitmatrix-memory read sequencer. Cyclic row addressing with
//           latency-matched row tags and a completed-pass counter.
// Revision: 1.0
// ============================================================================
module bm_mem_rd_seq #(
    parameter int M_MAX      = 128,
    parameter int M_MIN      = 2,
    parameter int RD_LAT     = 1,
    parameter int PASS_CNT_W = 16,
    parameter int MREG_W     = $clog2(M_MAX)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  eng_rstn,
    input  logic                  global_reg_wr_en,
    input  logic [MREG_W-1:0]     MReg,
    input  logic                  cntrl_bm_mem_rd_en,
    output logic                  bm_rd_en,
    output logic [MREG_W-1:0]     bm_rd_addr,
    output logic                  bm_row_vld,
    output logic [MREG_W-1:0]     bm_row_idx,
    output logic                  bm_last_row,
    output logic                  bm_pass_done,
    output logic [PASS_CNT_W-1:0] bm_pass_cnt,
    output logic                  seq_busy,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [MREG_W-1:0] M_MIN_V = MREG_W'(M_MIN);

    state_t              state;
    state_t              state_nxt;
    logic [MREG_W-1:0]   m_lat;
    logic [MREG_W-1:0]   addr_cnt;
    logic                addr_at_last;
    logic                eng_clr;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0]   last_pipe;
    logic [MREG_W-1:0]   idx_pipe [RD_LAT];
    logic                pipe_busy;
    logic                pipe_busy_after_shift;

    // rstn gates the issue path so every output reads 0 while reset is held
    assign bm_rd_en     = rstn & eng_rstn & ~global_reg_wr_en & cntrl_bm_mem_rd_en;
    assign bm_rd_addr   = addr_cnt;
    assign addr_at_last = (addr_cnt == m_lat - 1'b1);
    assign eng_clr      = ~eng_rstn & ~global_reg_wr_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lat    <= M_MIN_V;
            cfg_err  <= 1'b0;
            addr_cnt <= '0;
        end else if (global_reg_wr_en) begin
            m_lat    <= (MReg < M_MIN_V) ? M_MIN_V : MReg;
            cfg_err  <= (MReg < M_MIN_V);
            addr_cnt <= '0;
        end else if (!eng_rstn) begin
            addr_cnt <= '0;
        end else if (bm_rd_en) begin
            addr_cnt <= addr_at_last ? '0 : addr_cnt + 1'b1;
        end
    end

    // Tags ride alongside the memory read; idle slots carry all-zero tags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
        end else if (eng_clr) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= bm_rd_en;
            last_pipe[0] <= bm_rd_en & addr_at_last;
            idx_pipe[0]  <= bm_rd_en ? addr_cnt : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                idx_pipe[i]  <= idx_pipe[i-1];
            end
        end
    end

    assign bm_row_vld   = vld_pipe[RD_LAT-1];
    assign bm_last_row  = last_pipe[RD_LAT-1];
    assign bm_row_idx   = idx_pipe[RD_LAT-1];
    assign bm_pass_done = bm_row_vld & bm_last_row;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bm_pass_cnt <= '0;
        end else if (eng_clr) begin
            bm_pass_cnt <= '0;
        end else if (bm_pass_done) begin
            bm_pass_cnt <= bm_pass_cnt + 1'b1;
        end
    end

    always_comb begin
        pipe_busy             = |vld_pipe;
        pipe_busy_after_shift = bm_rd_en;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_busy_after_shift = pipe_busy_after_shift | vld_pipe[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!eng_rstn || global_reg_wr_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bm_rd_en) state_nxt = RUN;
                RUN:     if (!bm_rd_en) state_nxt = pipe_busy ? DRAIN : IDLE;
                DRAIN: begin
                    if (bm_rd_en)                   state_nxt = RUN;
                    else if (!pipe_busy_after_shift) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign seq_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bm_mem_rd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bm_mem_rd_seq
// Brief   : Scoreboard bench for bm_mem_rd_seq at read latencies 1 and 3.
// Revision: 1.0
// ============================================================================
module tb_bm_mem_rd_seq;

    localparam int MW = 7;
    localparam int PW = 16;

    typedef struct packed {
        logic [MW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          eng_rstn;
    logic          wr;
    logic [MW-1:0] mreg;
    logic          rd;

    logic          d1_rd_en, d1_vld, d1_last, d1_pd, d1_busy, d1_cerr;
    logic [MW-1:0] d1_addr, d1_idx;
    logic [PW-1:0] d1_pcnt;
    logic          d3_rd_en, d3_vld, d3_last, d3_pd, d3_busy, d3_cerr;
    logic [MW-1:0] d3_addr, d3_idx;
    logic [PW-1:0] d3_pcnt;

    exp_t q1[$];
    exp_t q3[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bm_mem_rd_seq #(.RD_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .global_reg_wr_en(wr),
        .MReg(mreg), .cntrl_bm_mem_rd_en(rd), .bm_rd_en(d1_rd_en), .bm_rd_addr(d1_addr),
        .bm_row_vld(d1_vld), .bm_row_idx(d1_idx), .bm_last_row(d1_last),
        .bm_pass_done(d1_pd), .bm_pass_cnt(d1_pcnt), .seq_busy(d1_busy), .cfg_err(d1_cerr)
    );

    bm_mem_rd_seq #(.RD_LAT(3)) dut3 (
        .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .global_reg_wr_en(wr),
        .MReg(mreg), .cntrl_bm_mem_rd_en(rd), .bm_rd_en(d3_rd_en), .bm_rd_addr(d3_addr),
        .bm_row_vld(d3_vld), .bm_row_idx(d3_idx), .bm_last_row(d3_last),
        .bm_pass_done(d3_pd), .bm_pass_cnt(d3_pcnt), .seq_busy(d3_busy), .cfg_err(d3_cerr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected row per valid output cycle
    always @(negedge clk) begin
        exp_t e;
        if (d1_vld === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d1 unexpected row: got idx %0d, expected no row (t=%0t)", d1_idx, $time);
            end else begin
                e = q1.pop_front();
                chk("d1 row_idx", 32'(d1_idx), 32'(e.idx));
                chk("d1 last_row", 32'(d1_last), 32'(e.last));
                chk("d1 pass_done", 32'(d1_pd), 32'(e.last));
            end
        end else begin
            chk("d1 idle tags", {29'd0, d1_idx != '0, d1_last, d1_pd}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (d3_vld === 1'b1) begin
            if (q3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d3 unexpected row: got idx %0d, expected no row (t=%0t)", d3_idx, $time);
            end else begin
                e = q3.pop_front();
                chk("d3 row_idx", 32'(d3_idx), 32'(e.idx));
                chk("d3 last_row", 32'(d3_last), 32'(e.last));
                chk("d3 pass_done", 32'(d3_pd), 32'(e.last));
            end
        end else begin
            chk("d3 idle tags", {29'd0, d3_idx != '0, d3_last, d3_pd}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One issue per cycle; idx nibble i and last bit i give the expected row for cycle i
    task automatic issue_seq(input int n, input logic [63:0] idxs, input logic [15:0] lasts);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rd = 1'b1;
            #1;
            e.idx  = MW'(idxs[4*i +: 4]);
            e.last = lasts[i];
            chk("d1 rd_en", 32'(d1_rd_en), 32'd1);
            chk("d1 rd_addr", 32'(d1_addr), 32'(e.idx));
            chk("d3 rd_addr", 32'(d3_addr), 32'(e.idx));
            q1.push_back(e);
            q3.push_back(e);
            tick();
        end
    endtask

    task automatic load(input logic [MW-1:0] m);
        wr   = 1'b1;
        mreg = m;
        #1;
        chk("load rd_en d1", 32'(d1_rd_en), 32'd0);
        chk("load rd_en d3", 32'(d3_rd_en), 32'd0);
        tick();
        wr = 1'b0;
    endtask

    // Four cycles after rd_en falls: RUN, DRAIN, then IDLE once the tag pipe empties
    task automatic busy_tail();
        logic [3:0] e1 = 4'b0011;
        logic [3:0] e3 = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("d1 seq_busy tail", 32'(d1_busy), 32'(e1[i]));
            chk("d3 seq_busy tail", 32'(d3_busy), 32'(e3[i]));
            tick();
        end
    endtask

    task automatic pcnt(input logic [PW-1:0] e);
        chk("d1 pass_cnt", 32'(d1_pcnt), 32'(e));
        chk("d3 pass_cnt", 32'(d3_pcnt), 32'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; eng_rstn = 1'b1; wr = 1'b0; mreg = '0; rd = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst rd_en", 32'(d1_rd_en), 32'd0);
        chk("rst rd_addr", 32'(d1_addr), 32'd0);
        chk("rst row_vld", 32'(d3_vld), 32'd0);
        chk("rst busy", 32'(d1_busy), 32'd0);
        chk("rst cfg_err", 32'(d3_cerr), 32'd0);
        pcnt(16'd0);
        rd = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // T1: M=4, ten reads
        load(7'd4);
        chk("T1 cfg_err", 32'(d1_cerr), 32'd0);
        chk("T1 busy idle", 32'(d1_busy), 32'd0);
        issue_seq(10, 64'h10_3210_3210, 16'h088);
        rd = 1'b0;
        busy_tail();
        repeat (2) tick();
        pcnt(16'd2);

        // T2: undersized M clamps to M_MIN
        load(7'd1);
        chk("T2 cfg_err d1", 32'(d1_cerr), 32'd1);
        chk("T2 cfg_err d3", 32'(d3_cerr), 32'd1);
        issue_seq(4, 64'h1010, 16'b1010);
        rd = 1'b0;
        repeat (6) tick();
        pcnt(16'd4);
        load(7'd5);
        chk("T2 cfg_err clr", 32'(d1_cerr), 32'd0);
        pcnt(16'd4);

        // T3: pause mid-pass, resume at held row
        load(7'd6);
        issue_seq(3, 64'h210, 16'b000);
        rd = 1'b0;
        busy_tail();
        issue_seq(4, 64'h0543, 16'b0100);
        rd = 1'b0;
        repeat (6) tick();
        pcnt(16'd5);

        // T4: engine clear discards in-flight rows
        load(7'd3);
        issue_seq(3, 64'h210, 16'b100);
        rd = 1'b0;
        tick();
        eng_rstn = 1'b0;
        rd = 1'b1;
        #1;
        chk("T4 clr rd_en d1", 32'(d1_rd_en), 32'd0);
        chk("T4 clr rd_en d3", 32'(d3_rd_en), 32'd0);
        tick();
        chk("T4 q1 drained", 32'(q1.size()), 32'd0);
        chk("T4 q3 discarded", 32'(q3.size()), 32'd1);
        q3.delete();
        pcnt(16'd0);
        chk("T4 busy d3", 32'(d3_busy), 32'd0);
        eng_rstn = 1'b1;
        issue_seq(2, 64'h10, 16'b00);
        rd = 1'b0;
        repeat (6) tick();

        // T5: load during read, then async reset mid-run
        rd = 1'b1;
        load(7'd3);
        issue_seq(2, 64'h10, 16'b00);
        #1;
        rstn = 1'b0;
        #1;
        chk("T5 rst rd_en", 32'(d1_rd_en), 32'd0);
        chk("T5 rst row_vld", 32'(d1_vld), 32'd0);
        chk("T5 rst busy d1", 32'(d1_busy), 32'd0);
        chk("T5 rst busy d3", 32'(d3_busy), 32'd0);
        chk("T5 rst addr", 32'(d1_addr), 32'd0);
        chk("T5 q1 pending", 32'(q1.size()), 32'd1);
        chk("T5 q3 pending", 32'(q3.size()), 32'd2);
        q1.delete();
        q3.delete();
        tick();
        rstn = 1'b1;
        issue_seq(3, 64'h010, 16'b010);
        rd = 1'b0;
        repeat (8) tick();
        pcnt(16'd1);
        chk("end cfg_err", 32'(d1_cerr), 32'd0);
        chk("end q1 empty", 32'(q1.size()), 32'd0);
        chk("end q3 empty", 32'(q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
